sec_min_stopwatch: RTL
======================

SEC_MIN_STOPWATCH -- requirements
Module: sec_min_stopwatch

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on clk_1s (legal 2..3).
REQ-002 Parameter MIN_MAX, default 59: highest minute value before wrap (legal 1..99).
REQ-003 clk  input  1  system clock; only clock in the block.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clk_1s  input  1  slow square wave from the 1 s divider, 50% duty, 1 s period; asynchronous to clk.
REQ-006 start  input  1  one-cycle command: begin or resume counting.
REQ-007 pause  input  1  one-cycle command: freeze counting.
REQ-008 clr  input  1  one-cycle command: zero the count and return to idle.
REQ-009 lap  input  1  one-cycle command: capture or release the lap display (see Configuration).
REQ-010 sec_lo, sec_hi, min_lo, min_hi  output  4 each  live BCD count, registered.
REQ-011 disp  output  16  displayed BCD value {min_hi,min_lo,sec_hi,sec_lo} or held lap value.
REQ-012 running  output  1  high in RUN state.
REQ-013 tick  output  1  one-cycle pulse per detected clk_1s rising edge, registered.
REQ-014 wrap  output  1  one-cycle pulse when the count rolls MIN_MAX:59 -> 00:00.

Function
REQ-015 clk_1s SHALL pass through SYNC_STAGES flops, then one history flop; tick SHALL be registered from (last sync flop & ~history flop).
REQ-016 With SYNC_STAGES=2, if clk edge N is the first to sample clk_1s high, tick SHALL be high for exactly the cycle after edge N+2; one tick per clk_1s period.
REQ-017 State machine states: IDLE, RUN, PAUSE.
REQ-018 Transitions: IDLE+start -> RUN; RUN+pause -> PAUSE; PAUSE+start -> RUN; any state+clr -> IDLE; all other commands ignored.
REQ-019 Command priority in the same cycle: clr > start > pause.
REQ-020 Count SHALL advance by 1 s on the clk edge that samples tick high and state RUN.
REQ-021 Tick sampled in IDLE or PAUSE SHALL be discarded, not deferred.
REQ-022 Tick and pause in the same cycle in RUN: tick counted, then PAUSE.
REQ-023 Tick and start in the same cycle in IDLE or PAUSE: tick not counted.
REQ-024 Tick and clr in the same cycle: count becomes 00:00, tick not counted.
REQ-025 BCD rules: sec_lo 9 -> 0 carries to sec_hi; sec_hi 5 with carry -> 0 carries to minutes; min_lo 9 -> 0 carries to min_hi; digits never exceed 9 (sec_hi 5).
REQ-026 At MIN_MAX:59 the next counted tick SHALL produce 00:00 and assert wrap for exactly one cycle, state remains RUN.
REQ-027 clr SHALL zero the count on the next clk edge regardless of state.

Reset
REQ-028 rst high SHALL immediately force: state IDLE, all BCD digits 0, disp 0, running 0, tick 0, wrap 0, synchronizer and history flops 0, lap hold cleared.
REQ-029 rst asserted mid-count SHALL abandon the count; after release, the first clk_1s rising edge seen SHALL not be counted unless state is RUN.

Configuration
REQ-030 Macro LAP_HOLD_EN defined: lap in RUN or PAUSE toggles a hold flag; on setting, current count is copied to a 16-bit lap register and disp shows it while the live count continues; on clearing, disp follows the live count again; clr clears the hold flag.
REQ-031 LAP_HOLD_EN undefined: lap port present but ignored; disp always equals the live count; no lap register is built.

Verification
REQ-032 Reset, start, 3 clk_1s rising edges -> count 00:03, three tick pulses, running=1.
REQ-033 Preload by counting to 00:59, one more edge -> 01:00; continue to MIN_MAX:59 (59:59), one more edge -> 00:00 and wrap=1 for one cycle.
REQ-034 RUN at 00:05, pause, 4 clk_1s edges, start, 1 edge -> 00:06.
REQ-035 tick coincident with clr at 00:09 -> 00:00, state IDLE; tick coincident with pause at 00:09 -> 00:10, state PAUSE.
REQ-036 LAP_HOLD_EN: lap at 00:12, 5 more edges -> disp=0x0012, sec=00:17; lap again -> disp=0x0017; without macro disp=0x0017 throughout.
REQ-037 rst asserted asynchronously mid-RUN at 00:30 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/sec_min_stopwatch.sv
// MM:SS BCD stopwatch counting rising edges of an asynchronous 1 s square wave.
// Optional lap display hold is built when LAP_HOLD_EN is defined.
module sec_min_stopwatch #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_MAX     = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_1s,
    input  logic        start,
    input  logic        pause,
    input  logic        clr,
    input  logic        lap,
    output logic [3:0]  sec_lo,
    output logic [3:0]  sec_hi,
    output logic [3:0]  min_lo,
    output logic [3:0]  min_hi,
    output logic [15:0] disp,
    output logic        running,
    output logic        tick,
    output logic        wrap
);

    // state | meaning
    // IDLE  | count held at 00:00 or last cleared value, ticks discarded
    // RUN   | counting one second per tick
    // PAUSE | count frozen, ticks discarded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_HI = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_LO = 4'(MIN_MAX % 10);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [15:0]            count;

    logic [3:0] inc_sec_lo;
    logic [3:0] inc_sec_hi;
    logic [3:0] inc_min_lo;
    logic [3:0] inc_min_hi;
    logic       inc_roll;

    assign count = {min_hi, min_lo, sec_hi, sec_lo};

    // Edge detector sits after the full synchronizer so only settled values are compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
            tick <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                sync <= {sync[SYNC_STAGES-2:0], clk_1s};
            else
                sync <= {SYNC_STAGES{clk_1s}};
            hist <= sync[SYNC_STAGES-1];
            tick <= sync[SYNC_STAGES-1] & ~hist;
        end
    end

    always_comb begin
        inc_sec_lo = sec_lo;
        inc_sec_hi = sec_hi;
        inc_min_lo = min_lo;
        inc_min_hi = min_hi;
        inc_roll   = 1'b0;
        if (sec_lo != 4'd9) begin
            inc_sec_lo = sec_lo + 4'd1;
        end else begin
            inc_sec_lo = 4'd0;
            if (sec_hi != 4'd5) begin
                inc_sec_hi = sec_hi + 4'd1;
            end else begin
                inc_sec_hi = 4'd0;
                if (min_hi == MAX_HI && min_lo == MAX_LO) begin
                    inc_min_lo = 4'd0;
                    inc_min_hi = 4'd0;
                    inc_roll   = 1'b1;
                end else if (min_lo != 4'd9) begin
                    inc_min_lo = min_lo + 4'd1;
                end else begin
                    inc_min_lo = 4'd0;
                    inc_min_hi = min_hi + 4'd1;
                end
            end
        end
    end

    // clr outranks everything; start in RUN simply keeps it running over pause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sec_lo  <= 4'd0;
            sec_hi  <= 4'd0;
            min_lo  <= 4'd0;
            min_hi  <= 4'd0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                state   <= IDLE;
                sec_lo  <= 4'd0;
                sec_hi  <= 4'd0;
                min_lo  <= 4'd0;
                min_hi  <= 4'd0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            sec_lo <= inc_sec_lo;
                            sec_hi <= inc_sec_hi;
                            min_lo <= inc_min_lo;
                            min_hi <= inc_min_hi;
                            wrap   <= inc_roll;
                        end
                        if (!start && pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic        hold;
    logic [15:0] lap_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold    <= 1'b0;
            lap_val <= 16'd0;
        end else if (clr) begin
            hold <= 1'b0;
        end else if (lap && (state == RUN || state == PAUSE)) begin
            hold <= ~hold;
            if (!hold)
                lap_val <= count;
        end
    end

    assign disp = hold ? lap_val : count;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = count;
`endif

endmodule
